// File: rtl/pc_fetch_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | pc_fetch_unit_pkg : shared fetch constants and FSM state encoding          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package pc_fetch_unit_pkg;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] fetch_state_t;

  localparam logic [1:0] ST_REQ  = 2'd0;  // free to issue a request
  localparam logic [1:0] ST_WAIT = 2'd1;  // one request outstanding
  localparam logic [1:0] ST_DROP = 2'd2;  // outstanding request squashed by redirect

endpackage

`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
// +----------------------------------------------------------------------------+
// | pc_fetch_unit_if : redirect, imem request/response and decode handoff bus  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pc_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic [DATA_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;
  logic [ADDR_W-1:0] pc_out;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready,
    output pc_out
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready,
    input  pc_out
  );

endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit_out_buf.sv
// +----------------------------------------------------------------------------+
// | fetch_out_buf : one-entry valid/ready instruction buffer with flush        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_out_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              flush,
  input  wire logic              load,
  input  wire logic [DATA_W-1:0] load_data,
  input  wire logic [ADDR_W-1:0] load_pc,
  input  wire logic              out_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [ADDR_W-1:0]      out_pc
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [ADDR_W-1:0] pc_q,    pc_d;

  // Flush wins over both load and drain; a consume in the flush cycle is void.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      pc_d    = load_pc;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_pc    = pc_q;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | pc_fetch_unit : fetch PC, single-outstanding imem sequencer, redirects     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input wire logic         CLK,
  input wire logic         Reset,
  pc_fetch_unit_if.master  bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;

  logic              req_valid;
  logic              req_fire;
  logic              buf_load;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_data;
  logic [ADDR_W-1:0] buf_pc;
  logic [ADDR_W-1:0] redirect_aligned;

  assign redirect_aligned = bus.redirect_pc & ~ADDR_W'(INSTR_BYTES - 1);

  // Issue only when the buffer will be free by the time the response lands.
  assign req_valid = (state_q == ST_REQ) && !bus.redirect_valid &&
                     (!buf_valid || bus.inst_ready) && !Reset;
  assign req_fire  = req_valid && bus.imem_req_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    buf_load = 1'b0;
    if (bus.redirect_valid) begin
      pc_d = redirect_aligned;
      case (state_q)
        ST_WAIT: state_d = bus.imem_rsp_valid ? ST_REQ : ST_DROP;
        ST_DROP: state_d = ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + ADDR_W'(INSTR_BYTES);
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            buf_load = 1'b1;
            state_d  = ST_REQ;
          end
        end
        ST_DROP: begin
          if (bus.imem_rsp_valid) begin
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_out_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk       (CLK),
    .rst       (Reset),
    .flush     (bus.redirect_valid),
    .load      (buf_load),
    .load_data (bus.imem_rsp_data),
    .load_pc   (req_pc_q),
    .out_ready (bus.inst_ready),
    .out_valid (buf_valid),
    .out_data  (buf_data),
    .out_pc    (buf_pc)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = buf_valid;
  assign bus.inst_data      = buf_data;
  assign bus.inst_pc        = buf_pc;
  assign bus.pc_out         = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// +----------------------------------------------------------------------------+
// | tb_pc_fetch_unit : directed self-checking bench for pc_fetch_unit          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) ifc  ();
  pc_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) ifc6 ();

  pc_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (ifc)
  );

  pc_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (32'hFFFF_FFFC)
  ) dut6 (
    .CLK   (clk),
    .Reset (rst),
    .bus   (ifc6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete fetch: accept at exp_addr, respond one cycle later, check the buffer.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data);
    chk("fetch_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    chk("fetch_req_addr", ifc.imem_req_addr, exp_addr);
    ifc.imem_req_ready = 1'b1;
    @(negedge clk);
    ifc.imem_req_ready = 1'b0;
    #1;
    chk("fetch_wait_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    chk("fetch_wait_inst_valid", 32'(ifc.inst_valid), 32'd0);
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = data;
    @(negedge clk);
    ifc.imem_rsp_valid = 1'b0;
    #1;
    chk("fetch_inst_valid", 32'(ifc.inst_valid), 32'd1);
    chk("fetch_inst_data", ifc.inst_data, data);
    chk("fetch_inst_pc", ifc.inst_pc, exp_addr);
  endtask

  initial begin
    rst = 1'b1;
    ifc.redirect_valid  = 1'b0;
    ifc.redirect_pc     = '0;
    ifc.imem_req_ready  = 1'b0;
    ifc.imem_rsp_valid  = 1'b0;
    ifc.imem_rsp_data   = '0;
    ifc.inst_ready      = 1'b0;
    ifc6.redirect_valid = 1'b0;
    ifc6.redirect_pc    = '0;
    ifc6.imem_req_ready = 1'b0;
    ifc6.imem_rsp_valid = 1'b0;
    ifc6.imem_rsp_data  = '0;
    ifc6.inst_ready     = 1'b1;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    chk("rst_pc_out", ifc.pc_out, 32'h0);
    chk("rst_inst_valid", 32'(ifc.inst_valid), 32'd0);
    chk("rst_inst_data", ifc.inst_data, 32'h0);
    chk("rst_inst_pc", ifc.inst_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    chk("first_req_addr", ifc.imem_req_addr, 32'h0);

    // Reset asserted while a request is outstanding
    ifc.imem_req_ready = 1'b1;
    @(negedge clk);
    ifc.imem_req_ready = 1'b0;
    #1;
    chk("wait_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    chk("wait_pc_out", ifc.pc_out, 32'h4);
    rst = 1'b1;
    #1;
    chk("async_rst_pc_out", ifc.pc_out, 32'h0);
    chk("async_rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_wait_inst_valid", 32'(ifc.inst_valid), 32'd0);
    chk("rst_wait_pc_out", ifc.pc_out, 32'h0);
    rst = 1'b0;
    #1;
    chk("rerelease_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    chk("rerelease_req_addr", ifc.imem_req_addr, 32'h0);

    // Stray response while idle is ignored
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    ifc.imem_rsp_valid = 1'b0;
    #1;
    chk("stray_rsp_inst_valid", 32'(ifc.inst_valid), 32'd0);
    chk("stray_rsp_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    chk("stray_rsp_req_addr", ifc.imem_req_addr, 32'h0);

    // Sequential fetch
    ifc.inst_ready = 1'b1;
    fetch(32'h0, 32'h1111_1111);
    fetch(32'h4, 32'h2222_2222);
    fetch(32'h8, 32'h3333_3333);

    // Backpressure from decode
    ifc.inst_ready = 1'b0;
    #1;
    chk("bp_req_valid_now", 32'(ifc.imem_req_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("bp_req_valid_held", 32'(ifc.imem_req_valid), 32'd0);
    chk("bp_inst_valid", 32'(ifc.inst_valid), 32'd1);
    chk("bp_inst_data", ifc.inst_data, 32'h3333_3333);
    chk("bp_inst_pc", ifc.inst_pc, 32'h8);
    ifc.inst_ready = 1'b1;
    #1;
    chk("bp_release_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    chk("bp_release_req_addr", ifc.imem_req_addr, 32'hC);
    fetch(32'hC, 32'h4444_4444);

    // Redirect while waiting; response arrives three cycles after acceptance
    ifc.imem_req_ready = 1'b1;
    @(negedge clk);
    ifc.imem_req_ready = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h40;
    #1;
    chk("redir_wait_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    #1;
    chk("drop_pc_out", ifc.pc_out, 32'h40);
    chk("drop_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    chk("drop_inst_valid", 32'(ifc.inst_valid), 32'd0);
    @(negedge clk);
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    ifc.imem_rsp_valid = 1'b0;
    #1;
    chk("drop_rsp_inst_valid", 32'(ifc.inst_valid), 32'd0);
    chk("drop_rsp_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    chk("drop_rsp_req_addr", ifc.imem_req_addr, 32'h40);
    fetch(32'h40, 32'h5555_5555);

    // Misaligned redirect with stray response and a consuming decode handshake
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h43;
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'hBAD1_BAD1;
    #1;
    chk("redir43_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    ifc.imem_rsp_valid = 1'b0;
    #1;
    chk("redir43_inst_valid", 32'(ifc.inst_valid), 32'd0);
    chk("redir43_pc_out", ifc.pc_out, 32'h40);
    chk("redir43_req_valid_after", 32'(ifc.imem_req_valid), 32'd1);
    chk("redir43_req_addr", ifc.imem_req_addr, 32'h40);

    // Redirect coincident with the response in WAIT: response dropped, no DROP state
    ifc.imem_req_ready = 1'b1;
    @(negedge clk);
    ifc.imem_req_ready = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h80;
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'hBAD2_BAD2;
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    ifc.imem_rsp_valid = 1'b0;
    #1;
    chk("redir_rsp_inst_valid", 32'(ifc.inst_valid), 32'd0);
    chk("redir_rsp_req_valid", 32'(ifc.imem_req_valid), 32'd1);
    chk("redir_rsp_req_addr", ifc.imem_req_addr, 32'h80);
    fetch(32'h80, 32'h6666_6666);

    // Back-to-back redirects: last one wins
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h100;
    @(negedge clk);
    ifc.redirect_pc    = 32'h200;
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    #1;
    chk("b2b_req_addr", ifc.imem_req_addr, 32'h200);
    chk("b2b_inst_valid", 32'(ifc.inst_valid), 32'd0);

    // Wrap of the fetch PC from RESET_PC = 0xFFFF_FFFC
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("wrap_first_req_valid", 32'(ifc6.imem_req_valid), 32'd1);
    chk("wrap_first_req_addr", ifc6.imem_req_addr, 32'hFFFF_FFFC);
    ifc6.imem_req_ready = 1'b1;
    @(negedge clk);
    ifc6.imem_req_ready = 1'b0;
    ifc6.imem_rsp_valid = 1'b1;
    ifc6.imem_rsp_data  = 32'h7777_7777;
    @(negedge clk);
    ifc6.imem_rsp_valid = 1'b0;
    #1;
    chk("wrap_inst_pc", ifc6.inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst_data", ifc6.inst_data, 32'h7777_7777);
    chk("wrap_pc_out", ifc6.pc_out, 32'h0);
    chk("wrap_second_req_valid", 32'(ifc6.imem_req_valid), 32'd1);
    chk("wrap_second_req_addr", ifc6.imem_req_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
